// File: rtl/pe_group_feeder_pkg.sv
// Shared definitions for the PE group feeder: per-tile word counts and FSM encoding.
package pe_group_feeder_pkg;

    localparam int DefWPeGroupSize = 4;
    localparam int DefOPeGroupSize = 4;
    localparam int DefBlockCount   = 4;

    function automatic int calcNW(input int wSize, input int blocks);
        return wSize * blocks;
    endfunction

    // Block 0 carries every edge input; later blocks only the bottom-row edge words.
    function automatic int calcNI(input int wSize, input int oSize, input int blocks);
        return (wSize + oSize - 1) + (blocks - 1) * wSize;
    endfunction

    function automatic int calcNO(input int oSize);
        return oSize;
    endfunction

    localparam int NW = calcNW(DefWPeGroupSize, DefBlockCount);
    localparam int NI = calcNI(DefWPeGroupSize, DefOPeGroupSize, DefBlockCount);
    localparam int NO = calcNO(DefOPeGroupSize);
    localparam int NR = calcNO(DefOPeGroupSize);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feederState_e;

endpackage

// File: rtl/pe_group_feeder_stream_reader.sv
// One SRAM-to-stream channel: issues reads ahead of the consumer and parks returning
// words in a 2-entry skid buffer so a dropped ready never loses or repeats a word.
module stream_reader #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 10,
    parameter int CountWidth = 6
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  start,
    input  logic [AddrWidth-1:0]  baseAddr,
    input  logic [CountWidth-1:0] len,
    output logic                  rdEn,
    output logic [AddrWidth-1:0]  addr,
    input  logic [DataWidth-1:0]  rdData,
    output logic                  valid,
    input  logic                  rdy,
    output logic [DataWidth-1:0]  data,
    output logic                  finished
);

    logic                  active_r;
    logic [AddrWidth-1:0]  base_r;
    logic [CountWidth-1:0] readCnt_r;
    logic [CountWidth-1:0] acceptCnt_r;
    logic                  rdEn_r;
    logic [AddrWidth-1:0]  addr_r;
    logic                  retValid_r;
    logic [DataWidth-1:0]  skidMem_r [2];
    logic                  skidHead_r;
    logic [1:0]            skidCnt_r;

    logic                  headValid_s;
    logic                  hs_s;
    logic                  bypass_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  tail_s;
    logic [2:0]            inFlight_s;
    logic                  issue_s;

    // Skid head has priority; an empty skid passes the returning SRAM word straight through.
    always_comb begin
        headValid_s = (skidCnt_r != 2'd0);
        valid       = headValid_s | retValid_r;
        data        = headValid_s ? skidMem_r[skidHead_r] : (retValid_r ? rdData : '0);
        hs_s        = valid & rdy;
        bypass_s    = ~headValid_s & retValid_r & rdy;
        push_s      = retValid_r & ~bypass_s;
        pop_s       = headValid_s & rdy;
        tail_s      = skidHead_r ^ skidCnt_r[0];
        inFlight_s  = {1'b0, skidCnt_r} + {2'b00, retValid_r} + {2'b00, rdEn_r};
        // Words held or in flight after this cycle, plus the new read, must fit in two entries.
        issue_s     = active_r && (readCnt_r < len) && (inFlight_s < (3'd2 + {2'b00, hs_s}));
        finished    = active_r && (acceptCnt_r == len);
        rdEn        = rdEn_r;
        addr        = addr_r;
    end

    // Read issue, counters and skid buffer state.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            active_r     <= 1'b0;
            base_r       <= '0;
            readCnt_r    <= '0;
            acceptCnt_r  <= '0;
            rdEn_r       <= 1'b0;
            addr_r       <= '0;
            retValid_r   <= 1'b0;
            skidMem_r[0] <= '0;
            skidMem_r[1] <= '0;
            skidHead_r   <= 1'b0;
            skidCnt_r    <= 2'd0;
        end else if (start) begin
            active_r    <= 1'b1;
            base_r      <= baseAddr;
            readCnt_r   <= (len != '0) ? CountWidth'(1) : '0;
            acceptCnt_r <= '0;
            rdEn_r      <= (len != '0);
            addr_r      <= baseAddr;
            retValid_r  <= 1'b0;
            skidHead_r  <= 1'b0;
            skidCnt_r   <= 2'd0;
        end else begin
            retValid_r <= rdEn_r;
            rdEn_r     <= issue_s;
            if (issue_s) begin
                addr_r    <= base_r + AddrWidth'(readCnt_r);
                readCnt_r <= readCnt_r + CountWidth'(1);
            end
            if (hs_s) begin
                acceptCnt_r <= acceptCnt_r + CountWidth'(1);
            end
            if (push_s) begin
                skidMem_r[tail_s] <= rdData;
            end
            if (pop_s) begin
                skidHead_r <= ~skidHead_r;
            end
            skidCnt_r <= skidCnt_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

endmodule

// File: rtl/pe_group_feeder.sv
// Tile sequencer for one PE group: streams W/I/O words from the tile SRAMs and
// writes the group's results back to the result bank.
module pe_group_feeder
    import pe_group_feeder_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 10,
    parameter int W_PEGroupSize = DefWPeGroupSize,
    parameter int O_PEGroupSize = DefOPeGroupSize,
    parameter int BlockCount    = DefBlockCount,
    parameter int CountWidth    = 6
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
    input  logic [AddrWidth-1:0] W_BaseAddr,
    input  logic [AddrWidth-1:0] I_BaseAddr,
    input  logic [AddrWidth-1:0] O_BaseAddr,
    input  logic [AddrWidth-1:0] R_BaseAddr,
    output logic                 W_MemRdEn,
    output logic                 I_MemRdEn,
    output logic                 O_MemRdEn,
    output logic [AddrWidth-1:0] W_MemAddr,
    output logic [AddrWidth-1:0] I_MemAddr,
    output logic [AddrWidth-1:0] O_MemAddr,
    input  logic [DataWidth-1:0] W_MemRdData,
    input  logic [DataWidth-1:0] I_MemRdData,
    input  logic [DataWidth-1:0] O_MemRdData,
    output logic                 W_DataOutValid,
    output logic                 I_DataOutValid,
    output logic                 O_DataOutValid,
    input  logic                 W_DataOutRdy,
    input  logic                 I_DataOutRdy,
    input  logic                 O_DataOutRdy,
    output logic [DataWidth-1:0] W_DataOut,
    output logic [DataWidth-1:0] I_DataOut,
    output logic [DataWidth-1:0] O_DataOut,
    input  logic                 Res_DataInValid,
    output logic                 Res_DataInRdy,
    input  logic [DataWidth-1:0] Res_DataIn,
    output logic                 R_MemWrEn,
    output logic [AddrWidth-1:0] R_MemAddr,
    output logic [DataWidth-1:0] R_MemWrData
);

    localparam int NumW = calcNW(W_PEGroupSize, BlockCount);
    localparam int NumI = calcNI(W_PEGroupSize, O_PEGroupSize, BlockCount);
    localparam int NumO = calcNO(O_PEGroupSize);
    localparam int NumR = calcNO(O_PEGroupSize);

    feederState_e          state_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  resRdy_r;
    logic [CountWidth-1:0] resCnt_r;
    logic [AddrWidth-1:0]  rBase_r;
    logic                  rWrEn_r;
    logic [AddrWidth-1:0]  rAddr_r;
    logic [DataWidth-1:0]  rData_r;

    logic                  streamStart_s;
    logic                  wFin_s;
    logic                  iFin_s;
    logic                  oFin_s;
    logic                  resHs_s;
    logic                  tileDone_s;

    // Start only counts in IDLE; results are accepted only while the collector is open.
    always_comb begin
        streamStart_s = Start && (state_r == IDLE);
        resHs_s       = Res_DataInValid && resRdy_r;
        tileDone_s    = wFin_s && iFin_s && oFin_s && (resCnt_r == CountWidth'(NumR));
        Busy          = busy_r;
        Done          = done_r;
        Res_DataInRdy = resRdy_r;
        R_MemWrEn     = rWrEn_r;
        R_MemAddr     = rAddr_r;
        R_MemWrData   = rData_r;
    end

    stream_reader #(.DataWidth(DataWidth), .AddrWidth(AddrWidth), .CountWidth(CountWidth)) uW (
        .clk(clk), .aclr(aclr), .start(streamStart_s), .baseAddr(W_BaseAddr),
        .len(CountWidth'(NumW)), .rdEn(W_MemRdEn), .addr(W_MemAddr), .rdData(W_MemRdData),
        .valid(W_DataOutValid), .rdy(W_DataOutRdy), .data(W_DataOut), .finished(wFin_s)
    );

    stream_reader #(.DataWidth(DataWidth), .AddrWidth(AddrWidth), .CountWidth(CountWidth)) uI (
        .clk(clk), .aclr(aclr), .start(streamStart_s), .baseAddr(I_BaseAddr),
        .len(CountWidth'(NumI)), .rdEn(I_MemRdEn), .addr(I_MemAddr), .rdData(I_MemRdData),
        .valid(I_DataOutValid), .rdy(I_DataOutRdy), .data(I_DataOut), .finished(iFin_s)
    );

    stream_reader #(.DataWidth(DataWidth), .AddrWidth(AddrWidth), .CountWidth(CountWidth)) uO (
        .clk(clk), .aclr(aclr), .start(streamStart_s), .baseAddr(O_BaseAddr),
        .len(CountWidth'(NumO)), .rdEn(O_MemRdEn), .addr(O_MemAddr), .rdData(O_MemRdData),
        .valid(O_DataOutValid), .rdy(O_DataOutRdy), .data(O_DataOut), .finished(oFin_s)
    );

    // Tile FSM and result collector; the last result write precedes the Done pulse.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            resRdy_r <= 1'b0;
            resCnt_r <= '0;
            rBase_r  <= '0;
            rWrEn_r  <= 1'b0;
            rAddr_r  <= '0;
            rData_r  <= '0;
        end else begin
            rWrEn_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        rBase_r  <= R_BaseAddr;
                        resCnt_r <= '0;
                        busy_r   <= 1'b1;
                        resRdy_r <= (NumR != 0);
                        state_r  <= RUN;
                    end else begin
                        resRdy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (resHs_s) begin
                        rWrEn_r  <= 1'b1;
                        rAddr_r  <= rBase_r + AddrWidth'(resCnt_r);
                        rData_r  <= Res_DataIn;
                        resCnt_r <= resCnt_r + CountWidth'(1);
                        resRdy_r <= ((resCnt_r + CountWidth'(1)) < CountWidth'(NumR));
                    end
                    if (tileDone_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    resRdy_r <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    resRdy_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pe_group_feeder.md
Name: pe_group_feeder

Overview:
- Transmit-side sequencer for the PE group's weight (W), input (I) and output (O) ready/valid streams, plus the receiver for its result stream.
- On a start pulse it reads one tile's W, I and partial-sum words from three local SRAM banks and streams them in the word order the PE group consumes.
- It collects the final accumulated results and writes them to a result bank.
- It sits between the tile SRAMs and one PE group.

Parameters:
- DataWidth, 32: width of every data word.
- AddrWidth, 10: SRAM address width.
- W_PEGroupSize, 4: PE columns; number of weights per block.
- O_PEGroupSize, 4: PE rows; number of partial sums and results.
- BlockCount, 4: number of blocks per tile.
- CountWidth, 6: width of the per-stream word counters; must hold the largest word count.

Ports:
- clk  in  1  clock.
- aclr  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle start pulse.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle pulse when the tile is complete.
- W_BaseAddr, I_BaseAddr, O_BaseAddr, R_BaseAddr  in  AddrWidth each  bank base addresses; sampled on Start.
- W_MemRdEn, I_MemRdEn, O_MemRdEn  out  1 each  SRAM read enables.
- W_MemAddr, I_MemAddr, O_MemAddr  out  AddrWidth each  SRAM read addresses.
- W_MemRdData, I_MemRdData, O_MemRdData  in  DataWidth each  read data, valid exactly 1 cycle after the corresponding RdEn.
- W_DataOutValid, I_DataOutValid, O_DataOutValid  out  1 each  stream valids to the PE group.
- W_DataOutRdy, I_DataOutRdy, O_DataOutRdy  in  1 each  stream readies from the PE group.
- W_DataOut, I_DataOut, O_DataOut  out  DataWidth each  stream data.
- Res_DataInValid  in  1  result valid from the PE group.
- Res_DataInRdy  out  1  result ready to the PE group.
- Res_DataIn  in  DataWidth  result data.
- R_MemWrEn  out  1  result SRAM write enable.
- R_MemAddr  out  AddrWidth  result SRAM write address.
- R_MemWrData  out  DataWidth  result SRAM write data.

Behaviour:
- Reset (aclr low, asynchronous): every output is 0, FSM goes to IDLE, all counters and skid buffers are cleared.
- Reset mid-tile abandons the tile; no Done pulse is generated.
- Word counts per tile:
  - NW = W_PEGroupSize*BlockCount (16).
  - NI = (W_PEGroupSize+O_PEGroupSize-1) + (BlockCount-1)*W_PEGroupSize (19). Block 0 carries all edge inputs; later blocks carry only the bottom-row edge words, because the other inputs recirculate inside the group.
  - NO = O_PEGroupSize (4), partial sums for block 0 only.
  - NR = O_PEGroupSize (4) results.
- Addresses: read word k of a stream from Base+k. Result word k is written to R_BaseAddr+k. Address sums wrap modulo 2^AddrWidth.
- FSM states:
  - IDLE: Start latches the bases, clears the counters and moves to RUN; Busy goes high the next cycle.
  - RUN: the three stream channels and the result collector operate concurrently and independently. Move to DONE when all NW/NI/NO words have been handshaken and NR results have been written.
  - DONE: Done=1 for one cycle, Busy drops in the same cycle, then return to IDLE.
  - Start in any state other than IDLE is ignored.
- Stream channel (one per W/I/O):
  - Issue a read when the words read are fewer than N and the skid buffer can accept a word, counting reads in flight.
  - The first RdEn occurs in the cycle after Start. The first DataOutValid occurs 2 cycles after Start.
  - With Rdy held high the channel sustains 1 word/cycle with no bubbles.
  - Once DataOutValid is high, DataOutValid and DataOut stay stable until a handshake (Valid & Rdy).
  - When Rdy drops, the in-flight read word is captured in the skid entry and never lost or duplicated.
  - After the Nth handshake, Valid stays 0 and no further reads are issued.
- Result collector:
  - Res_DataInRdy = 1 only in RUN while fewer than NR results have been accepted; otherwise 0.
  - Each handshake registers R_MemWrEn=1 with its address and data in the next cycle.
  - Done pulses in the cycle after the last write.
- Simultaneous events: handshakes on all four interfaces in one cycle are legal and are handled independently.

Decomposition:
- Shared package holds:
  - word-count constants NW/NI/NO/NR, derived from the group-size parameters;
  - the FSM state encoding (IDLE, RUN, DONE).
- One sub-module, stream_reader, is instantiated three times. It provides base address, length, start, RdEn/Addr/RdData, Valid/Rdy/Data, and a finished flag. It contains the 2-entry skid buffer and the read/accept counters.

Test Plan:
- Reset, then one Start with Base=0 and all Rdy held 1:
  - W_MemRdEn first asserts 1 cycle after Start, W_DataOutValid 2 cycles after;
  - exactly 16 W, 19 I and 4 O words, in address order, with no bubbles;
  - results 0xA..0xD are written to R addresses 0..3;
  - Done pulses once.
- W_DataOutRdy toggled with a 1-0 pattern, I_DataOutRdy held 0 for 10 cycles:
  - every word is delivered exactly once, in order;
  - data is stable while Valid=1 and Rdy=0.
- W_BaseAddr = 2^AddrWidth-3: addresses wrap to 0 after 1023, giving 1021, 1022, 1023, 0, …
- Start pulsed again during RUN: ignored; counts are unchanged and a single Done pulse occurs.
- aclr asserted after 7 W words: all outputs read 0 immediately. A new Start after release streams from word 0 and produces no stale Done.
- Res_DataInValid=1 while IDLE: Res_DataInRdy=0 and no R_MemWrEn. A fifth result after NR results is not accepted.
